// File: rtl/mux_channel_scanner.sv
// Feeder for a 4-to-1 nibble mux: four write-port channel registers, with round-robin
// selection of pending channels offered to a consumer over a valid/ready handshake.
module mux_channel_scanner (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [3:0]  wr_data,
  output logic        wr_ready,
  output logic [15:0] D,
  output logic [1:0]  S,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  pending,
  output logic [3:0]  overrun,
  input  logic        clr_overrun
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state_q, state_d;
  logic [3:0] ch_q [4];
  logic [3:0] pending_q, pending_d;
  logic [3:0] overrun_q, overrun_d;
  logic [1:0] s_q, s_d;
  logic [1:0] ptr_q, ptr_d;
  logic       handshake;
  logic       wr_acc;

  // First set bit of 'set', scanning start, start+1, ... with wrap.
  function automatic logic [1:0] first_from(input logic [3:0] set, input logic [1:0] start);
    logic [1:0] idx;
    first_from = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (set[idx]) first_from = idx;
    end
  endfunction

  assign out_valid = (state_q == PRESENT);
  assign S         = s_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;
  assign D         = {ch_q[3], ch_q[2], ch_q[1], ch_q[0]};
  // The offered channel is write-protected so the mux output cannot move under the consumer.
  assign wr_ready  = !(out_valid && (wr_addr == s_q));
  assign handshake = out_valid && out_ready;
  assign wr_acc    = wr_en && wr_ready;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
    state_d   = state_q;
    s_d       = s_q;
    ptr_d     = ptr_q;
    pending_d = pending_q;
    overrun_d = overrun_q;

    if (handshake) pending_d[s_q] = 1'b0;
    if (wr_acc)    pending_d[wr_addr] = 1'b1;

    if (clr_overrun) overrun_d = '0;
    if (wr_acc && pending_q[wr_addr]) overrun_d[wr_addr] = 1'b1;

    case (state_q)
      IDLE: begin
        if (pending_q != '0) begin
          s_d     = first_from(pending_q, ptr_q);
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (handshake) begin
          ptr_d = s_q + 2'd1;
          // Same-cycle writes are already folded into pending_d, so there is no bubble.
          if (pending_d != '0) s_d = first_from(pending_d, s_q + 2'd1);
          else                 state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the channel array is reset on purpose, because D exposes it directly and must read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) ch_q[i] <= '0;
    end else if (wr_acc) begin
      ch_q[wr_addr] <= wr_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Directed bench for mux_channel_scanner: a behavioural model is checked on every falling
// edge, and literal expectations pin the model at the key points of each scenario.
module tb_mux_channel_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, out_ready, clr_overrun;
  logic [1:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        wr_ready, out_valid;
  logic [15:0] D;
  logic [1:0]  S;
  logic [3:0]  pending, overrun;

  int n_cmp = 0;
  int n_err = 0;

  mux_channel_scanner dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .D(D), .S(S), .out_valid(out_valid), .out_ready(out_ready),
    .pending(pending), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: channel contents, pending/overrun sets, and the offered channel.
  logic [3:0] m_ch [4];
  logic [3:0] m_pend, m_ovr;
  bit         m_valid;
  int         m_s, m_ptr;

  function automatic int scan(input logic [3:0] set, input int start);
    for (int k = 0; k < 4; k++)
      if (set[(start + k) % 4]) return (start + k) % 4;
    return start;
  endfunction

  function automatic bit m_wr_ready();
    return !(m_valid && (int'(wr_addr) == m_s));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_ch[i] = 4'h0;
      m_pend = 4'h0; m_ovr = 4'h0; m_valid = 0; m_s = 0; m_ptr = 0;
    end else begin
      bit         acc, hs;
      logic [3:0] old_pend;
      acc      = wr_en && m_wr_ready();
      hs       = m_valid && out_ready;
      old_pend = m_pend;
      if (hs) begin
        m_pend[m_s] = 1'b0;
        m_ptr = (m_s + 1) % 4;
      end
      if (clr_overrun) m_ovr = 4'h0;
      if (acc) begin
        if (old_pend[wr_addr]) m_ovr[wr_addr] = 1'b1;
        m_pend[wr_addr] = 1'b1;
        m_ch[wr_addr]   = wr_data;
      end
      if (!m_valid) begin
        if (old_pend != 0) begin
          m_s = scan(old_pend, m_ptr);
          m_valid = 1;
        end
      end else if (hs) begin
        if (m_pend != 0) m_s = scan(m_pend, m_ptr);
        else             m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("cyc_out_valid", 16'(out_valid), 16'(m_valid));
      check("cyc_S",         16'(S),         16'(m_s));
      check("cyc_D",         D,              {m_ch[3], m_ch[2], m_ch[1], m_ch[0]});
      check("cyc_pending",   16'(pending),   16'(m_pend));
      check("cyc_overrun",   16'(overrun),   16'(m_ovr));
      check("cyc_wr_ready",  16'(wr_ready),  16'(m_wr_ready()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'h0;
    out_ready = 1'b0; clr_overrun = 1'b0;
    #3;
    check("por_valid", 16'(out_valid), 16'h0);
    check("por_D", D, 16'h0);
    check("por_wr_ready", 16'(wr_ready), 16'h1);
    @(negedge clk); rst = 1'b0;
    step();

    // Single write with one-cycle presentation latency.
    out_ready = 1'b1; wr(2'd2, 4'hA);
    step(); wr_en = 1'b0;
    check("lat_pending", 16'(pending), 16'h4);
    check("lat_valid_lo", 16'(out_valid), 16'h0);
    step();
    check("lat_valid_hi", 16'(out_valid), 16'h1);
    check("lat_S", 16'(S), 16'h2);
    check("lat_nibble", 16'(D[11:8]), 16'hA);
    step();
    check("lat_idle", 16'(out_valid), 16'h0);
    check("lat_cleared", 16'(pending), 16'h0);

    // Round-robin over 0,1,3 then wrap to 0.
    out_ready = 1'b0;
    wr(2'd0, 4'h1); step();
    wr(2'd1, 4'h2); step();
    wr(2'd3, 4'h3); step();
    wr_en = 1'b0;
    check("rr_S0", 16'(S), 16'h0);
    check("rr_pending", 16'(pending), 16'hB);
    out_ready = 1'b1;
    step(); check("rr_S1", 16'(S), 16'h1);
    step(); check("rr_S3", 16'(S), 16'h3);
    check("rr_D3", 16'(D[15:12]), 16'h3);
    step(); check("rr_idle", 16'(out_valid), 16'h0);
    wr(2'd0, 4'h4); step(); wr_en = 1'b0;
    step();
    check("wrap_S", 16'(S), 16'h0);
    check("wrap_valid", 16'(out_valid), 16'h1);
    step();

    // Stall on ch1: writes to ch1 refused, ch2 accepted.
    out_ready = 1'b0;
    wr(2'd1, 4'h7); step(); wr_en = 1'b0;
    step();
    check("stall_S", 16'(S), 16'h1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        wr(2'd2, 4'h9); #1;
        check("stall_wr2_ready", 16'(wr_ready), 16'h1);
      end else begin
        wr(2'd1, 4'hF); #1;
        check("stall_wr1_ready", 16'(wr_ready), 16'h0);
      end
      step();
      check("stall_S_hold", 16'(S), 16'h1);
      check("stall_D1_hold", 16'(D[7:4]), 16'h7);
    end
    wr_en = 1'b0;
    check("stall_pending", 16'(pending), 16'h6);
    out_ready = 1'b1;
    step();
    check("stall_next_S", 16'(S), 16'h2);
    check("stall_D2", 16'(D[11:8]), 16'h9);
    step();

    // Overrun on ch3; set beats a same-cycle clear.
    out_ready = 1'b0;
    wr(2'd3, 4'h5); step();
    wr(2'd3, 4'h6); step(); wr_en = 1'b0;
    check("ovr_flag", 16'(overrun), 16'h8);
    check("ovr_S", 16'(S), 16'h3);
    check("ovr_value", 16'(D[15:12]), 16'h6);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    wr(2'd3, 4'h1); step();
    wr(2'd3, 4'h2); clr_overrun = 1'b1; step();
    wr_en = 1'b0;
    check("ovr_set_wins", 16'(overrun), 16'h8);
    out_ready = 1'b1; step();
    clr_overrun = 1'b0;
    check("ovr_cleared", 16'(overrun), 16'h0);

    // Handshake on ch0 with a same-cycle write to ch2: no bubble.
    out_ready = 1'b0;
    wr(2'd0, 4'hC); step(); wr_en = 1'b0;
    step();
    check("hs_S0", 16'(S), 16'h0);
    out_ready = 1'b1; wr(2'd2, 4'hD); step(); wr_en = 1'b0;
    check("hs_S2", 16'(S), 16'h2);
    check("hs_no_bubble", 16'(out_valid), 16'h1);
    step();

    // Reset in the middle of PRESENT with pending = 1010.
    out_ready = 1'b0;
    wr(2'd1, 4'h3); step();
    wr(2'd3, 4'h5); step(); wr_en = 1'b0;
    check("rst_pre_pending", 16'(pending), 16'hA);
    check("rst_pre_valid", 16'(out_valid), 16'h1);
    #2 rst = 1'b1; #1;
    check("rst_valid", 16'(out_valid), 16'h0);
    check("rst_S", 16'(S), 16'h0);
    check("rst_pending", 16'(pending), 16'h0);
    check("rst_D", D, 16'h0);
    check("rst_overrun", 16'(overrun), 16'h0);
    @(negedge clk); rst = 1'b0;
    wr(2'd1, 4'hE); step(); wr_en = 1'b0;
    step();
    check("post_rst_S", 16'(S), 16'h1);
    out_ready = 1'b1; step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
